// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

  // Command/data phase of the SPI register protocol
  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [2:0]  STATUS_ADDR_DEF = 3'd7;
  localparam logic [7:0]  ID_BYTE_DEF     = 8'hA5;

  // Words presented to the SPI slave between transactions and on a bad command
  localparam logic [15:0] TX_IDLE = 16'h0000;
  localparam logic [15:0] TX_ERR  = 16'hFFFF;

  // Increment that sticks at all-ones
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_ste_sync.sv
// Two-flop synchronizer for the SPI chip select plus a rising-edge detector.
module spi_ste_sync (
  input  logic clk_100,
  input  logic RST,
  input  logic SPISTE,
  output logic ste_rise
);

  logic ste_meta;
  logic ste_sync;
  logic ste_prev;

  // Chip select idles high, so all stages reset to 1 to avoid a false edge
  always_ff @(posedge clk_100) begin
    if (RST) begin
      ste_meta <= 1'b1;
      ste_sync <= 1'b1;
      ste_prev <= 1'b1;
    end else begin
      ste_meta <= SPISTE;
      ste_sync <= ste_meta;
      ste_prev <= ste_sync;
    end
  end

  assign ste_rise = ste_sync & ~ste_prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-driven register file: command frame selects address/direction, the
// following data frame completes the access. A local port shares the
// registers; on a same-address clash the SPI write wins.
//
// Handshake: rxd_flag is a one-cycle valid with no ready; every pulse is
// consumed in the cycle it is seen. lcl_wr_en is likewise always accepted.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [2:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [7:0] ID_BYTE     = ID_BYTE_DEF
) (
  input  logic        clk_100,
  input  logic        RST,
  input  logic        SPISTE,
  input  logic [15:0] rxd_data,
  input  logic        rxd_flag,
  output logic [15:0] txd_data,
  input  logic        lcl_wr_en,
  input  logic [2:0]  lcl_addr,
  input  logic [15:0] lcl_wdata,
  output logic [15:0] lcl_rdata,
  output logic        lcl_collide,
  output logic        spi_wr_pulse,
  output logic [2:0]  spi_wr_addr,
  output logic [7:0]  err_cnt,
  output logic        busy,
  output state_t      state_dbg
);

  state_t      state;
  state_t      next_state;
  logic        cmd_rd;
  logic [2:0]  cmd_addr;
  logic [15:0] regs [8];
  logic        ste_rise;

  logic        cmd_valid;
  logic        cmd_load;
  logic        cmd_bad;
  logic        data_done;
  logic        abort;
  logic        spi_wr;
  logic        status_wr_err;
  logic        lcl_wr;
  logic        collide;
  logic        err_inc;
  logic [15:0] status_word;
  logic [15:0] cmd_rword;
  logic [15:0] lcl_rword;

  spi_ste_sync u_ste_sync (
    .clk_100  (clk_100),
    .RST      (RST),
    .SPISTE   (SPISTE),
    .ste_rise (ste_rise)
  );

  assign cmd_valid     = (rxd_data[14:3] == 12'd0);
  assign status_word   = {ID_BYTE, err_cnt};
  assign cmd_rword     = (rxd_data[2:0] == STATUS_ADDR) ? status_word : regs[rxd_data[2:0]];
  assign lcl_rword     = (lcl_addr == STATUS_ADDR) ? status_word : regs[lcl_addr];
  assign spi_wr        = data_done && !cmd_rd && (cmd_addr != STATUS_ADDR);
  assign status_wr_err = data_done && !cmd_rd && (cmd_addr == STATUS_ADDR);
  assign lcl_wr        = lcl_wr_en && (lcl_addr != STATUS_ADDR);
  assign collide       = spi_wr && lcl_wr && (lcl_addr == cmd_addr);
  assign err_inc       = cmd_bad | status_wr_err | abort;
  assign busy          = (state == DATA);
  assign state_dbg     = state;

  // State register
  always_ff @(posedge clk_100) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and decode strobes; a frame in DATA takes priority over abort
  always_comb begin
    next_state = state;
    cmd_load   = 1'b0;
    cmd_bad    = 1'b0;
    data_done  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_flag) begin
          if (cmd_valid) begin
            next_state = DATA;
            cmd_load   = 1'b1;
          end else begin
            cmd_bad = 1'b1;
          end
        end
      end
      DATA: begin
        if (rxd_flag) begin
          next_state = IDLE;
          data_done  = 1'b1;
        end else if (ste_rise) begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch direction and address of a decoded command
  always_ff @(posedge clk_100) begin
    if (RST) begin
      cmd_rd   <= 1'b0;
      cmd_addr <= 3'd0;
    end else if (cmd_load) begin
      cmd_rd   <= rxd_data[15];
      cmd_addr <= rxd_data[2:0];
    end
  end

  // Transmit word: read data is snapshotted at decode and then held
  always_ff @(posedge clk_100) begin
    if (RST)                    txd_data <= TX_IDLE;
    else if (cmd_load)          txd_data <= rxd_data[15] ? cmd_rword : TX_IDLE;
    else if (cmd_bad)           txd_data <= TX_ERR;
    else if (data_done || abort) txd_data <= TX_IDLE;
  end

  // Register file; the SPI write takes a clashing address from the local port
  always_ff @(posedge clk_100) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
    end else begin
      if (lcl_wr && !collide) regs[lcl_addr] <= lcl_wdata;
      if (spi_wr)             regs[cmd_addr] <= rxd_data;
    end
  end

  // Saturating protocol-error counter
  always_ff @(posedge clk_100) begin
    if (RST)          err_cnt <= 8'd0;
    else if (err_inc) err_cnt <= sat_inc(err_cnt);
  end

  // Status pulses, last SPI write address and registered local read
  always_ff @(posedge clk_100) begin
    if (RST) begin
      spi_wr_pulse <= 1'b0;
      lcl_collide  <= 1'b0;
      spi_wr_addr  <= 3'd0;
      lcl_rdata    <= 16'd0;
    end else begin
      spi_wr_pulse <= spi_wr;
      lcl_collide  <= collide;
      if (spi_wr) spi_wr_addr <= cmd_addr;
      lcl_rdata    <= lcl_rword;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized bench for spi_reg_ctrl with a transaction-level model.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  // Clock and DUT signals
  logic        clk_100 = 1'b0;
  logic        RST = 1'b1;
  logic        SPISTE = 1'b0;
  logic [15:0] rxd_data = 16'd0;
  logic        rxd_flag = 1'b0;
  logic [15:0] txd_data;
  logic        lcl_wr_en = 1'b0;
  logic [2:0]  lcl_addr = 3'd0;
  logic [15:0] lcl_wdata = 16'd0;
  logic [15:0] lcl_rdata;
  logic        lcl_collide;
  logic        spi_wr_pulse;
  logic [2:0]  spi_wr_addr;
  logic [7:0]  err_cnt;
  logic        busy;
  state_t      state_dbg;

  always #5 clk_100 = ~clk_100;

  spi_reg_ctrl dut (
    .clk_100      (clk_100),
    .RST          (RST),
    .SPISTE       (SPISTE),
    .rxd_data     (rxd_data),
    .rxd_flag     (rxd_flag),
    .txd_data     (txd_data),
    .lcl_wr_en    (lcl_wr_en),
    .lcl_addr     (lcl_addr),
    .lcl_wdata    (lcl_wdata),
    .lcl_rdata    (lcl_rdata),
    .lcl_collide  (lcl_collide),
    .spi_wr_pulse (spi_wr_pulse),
    .spi_wr_addr  (spi_wr_addr),
    .err_cnt      (err_cnt),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: transaction-level view of the register block
  logic [15:0] m_regs [8];
  int          m_err_n;
  bit          m_busy;
  bit          m_rd;
  logic [2:0]  m_addr;
  logic [2:0]  m_wr_addr;
  logic [15:0] m_txd;
  bit          exp_pulse;
  bit          exp_coll;

  function automatic logic [7:0] m_err();
    return (m_err_n > 255) ? 8'hFF : 8'(m_err_n);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    return (a == 3'd7) ? {8'hA5, m_err()} : m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    m_err_n = 0; m_busy = 0; m_rd = 0; m_addr = 3'd0; m_wr_addr = 3'd0;
    m_txd = 16'd0; exp_pulse = 0; exp_coll = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".txd"},    txd_data,             m_txd);
    chk({tag, ".busy"},   16'(busy),            16'(m_busy));
    chk({tag, ".err"},    16'(err_cnt),         16'(m_err()));
    chk({tag, ".pulse"},  16'(spi_wr_pulse),    16'(exp_pulse));
    chk({tag, ".coll"},   16'(lcl_collide),     16'(exp_coll));
    chk({tag, ".wraddr"}, 16'(spi_wr_addr),     16'(m_wr_addr));
  endtask

  // One SPI frame, optionally with a concurrent local write
  task automatic frame(input logic [15:0] d, input logic le = 1'b0,
                       input logic [2:0] la = 3'd0, input logic [15:0] lw = 16'd0);
    rxd_data = d; rxd_flag = 1'b1;
    lcl_wr_en = le; lcl_addr = la; lcl_wdata = lw;
    tick();
    rxd_flag = 1'b0; lcl_wr_en = 1'b0;
    exp_pulse = 0; exp_coll = 0;
    if (!m_busy) begin
      if (d[14:3] != 12'd0) begin
        m_err_n++;
        m_txd = 16'hFFFF;
      end else begin
        m_rd = d[15]; m_addr = d[2:0]; m_busy = 1;
        m_txd = m_rd ? m_read(m_addr) : 16'h0000;
      end
    end else begin
      m_busy = 0; m_txd = 16'h0000;
      if (!m_rd) begin
        if (m_addr == 3'd7) m_err_n++;
        else begin m_regs[m_addr] = d; exp_pulse = 1; m_wr_addr = m_addr; end
      end
    end
    if (le && la != 3'd7) begin
      if (exp_pulse && la == m_addr) exp_coll = 1;
      else m_regs[la] = lw;
    end
    chk_outputs("frame");
    tick();
    exp_pulse = 0; exp_coll = 0;
    chk_outputs("after_frame");
  endtask

  task automatic lwrite(input logic [2:0] a, input logic [15:0] d);
    lcl_wr_en = 1'b1; lcl_addr = a; lcl_wdata = d;
    tick();
    lcl_wr_en = 1'b0;
    if (a != 3'd7) m_regs[a] = d;
    chk("lwrite.err", 16'(err_cnt), 16'(m_err()));
  endtask

  task automatic lcheck(input logic [2:0] a);
    lcl_addr = a;
    tick();
    chk("lcl_rdata", lcl_rdata, m_read(a));
  endtask

  task automatic abort_seq();
    SPISTE = 1'b1;
    repeat (4) tick();
    if (m_busy) begin m_err_n++; m_busy = 0; m_txd = 16'h0000; end
    chk_outputs("abort");
    SPISTE = 1'b0;
    repeat (3) tick();
    chk_outputs("abort_low");
  endtask

  task automatic chk_reset_state();
    chk("rst.txd",    txd_data,          16'h0000);
    chk("rst.rdata",  lcl_rdata,         16'h0000);
    chk("rst.busy",   16'(busy),         16'h0000);
    chk("rst.err",    16'(err_cnt),      16'h0000);
    chk("rst.pulse",  16'(spi_wr_pulse), 16'h0000);
    chk("rst.coll",   16'(lcl_collide),  16'h0000);
    chk("rst.wraddr", 16'(spi_wr_addr),  16'h0000);
  endtask

  initial begin
    model_reset();
    // Reset
    RST = 1'b1;
    repeat (2) tick();
    chk_reset_state();
    RST = 1'b0;
    tick();

    // SPI write then read-back of reg3, snapshot immune to a later local write
    frame(16'h0003);
    frame(16'h1234);
    lcheck(3'd3);
    frame(16'h8003);
    lwrite(3'd3, 16'hCAFE);
    chk("snapshot.txd", txd_data, 16'h1234);
    frame(16'hBEEF);
    lcheck(3'd3);

    // Status read and bad command
    frame(16'h0008);
    frame(16'h0010);
    frame(16'h8007);
    frame(16'h0000);
    frame(16'h0408);

    // Abort during DATA, then next frame is a command
    frame(16'h0005);
    abort_seq();
    frame(16'h8005);
    frame(16'h0000);

    // Abort while idle has no effect
    abort_seq();

    // Frame and abort in the same cycle: frame wins
    frame(16'h0006);
    SPISTE = 1'b1;
    tick(); tick();
    frame(16'h7777);
    SPISTE = 1'b0;
    repeat (3) tick();
    lcheck(3'd6);

    // SPI/local collisions
    frame(16'h0002);
    frame(16'h00AA, 1'b1, 3'd2, 16'h0055);
    lcheck(3'd2);
    frame(16'h0002);
    frame(16'h00AA, 1'b1, 3'd4, 16'h0055);
    lcheck(3'd2);
    lcheck(3'd4);

    // Local write to status is ignored; SPI write to status is an error
    lwrite(3'd7, 16'h1111);
    lcheck(3'd7);
    frame(16'h0007);
    frame(16'h2222);
    lcheck(3'd7);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        frame({1'($urandom_range(0, 1)), 12'($urandom_range(1, 4095)), 3'($urandom_range(0, 7))});
      end else begin
        frame({1'($urandom_range(0, 1)), 12'd0, 3'($urandom_range(0, 7))},
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        if (kind == 9) abort_seq();
        else frame(16'($urandom), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 16'($urandom));
      end
      lcheck(3'($urandom_range(0, 7)));
    end

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      frame({1'($urandom_range(0, 1)), 12'($urandom_range(1, 4095)), 3'($urandom_range(0, 7))});
    end
    chk("sat.err", 16'(err_cnt), 16'h00FF);
    lcheck(3'd7);

    // Reset in the middle of a transaction
    frame(16'h0001);
    RST = 1'b1;
    tick();
    chk_reset_state();
    RST = 1'b0;
    model_reset();
    tick();
    frame(16'h8001);
    frame(16'h0000);
    lcheck(3'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
